// File: rtl/vga_pkg.sv
// Shared timing constants, pixel/timing types and the total-count helper for the video timing path.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Raw, polarity-free timing: every field is 1 when the condition holds.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0};

    function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth delay line for raw de/hs/vs, matching the pixel source latency; depth 0 is a wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  timing_t din,
    output timing_t dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            timing_t stage_q [DEPTH];
            timing_t stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // NOTE: every stage is reset, so no pre-reset de/sync can leak out after release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= TIMING_IDLE;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Parametrised video timing generator: pixel request counters, latency-aligned registered
// syncs/de/RGB for the TMDS encoder, line/frame strobes and a frame counter.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_LAT  = 2,
    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    output logic [HW-1:0] px,
    output logic [VW-1:0] py,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b
);

    if (H_FP < 1 || H_BP < 1 || V_FP < 1 || V_BP < 1) begin : g_bad_porch
        $error("vga_timing: every porch must be at least 1");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vga_timing: sync widths must be at least 1");
    end
    if (PIX_LAT > 15) begin : g_bad_lat
        $error("vga_timing: PIX_LAT must be in 0..15");
    end

    logic [HW-1:0] px_q, px_d;
    logic [VW-1:0] py_q, py_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    rgb888_t       vga_q, vga_d;
    logic          px_wrap, py_wrap;
    timing_t       raw, dly;
    rgb888_t       pix_in;

    assign pix_in = '{r: r, g: g, b: b};

    // NOTE: always_comb gives every output a value on every path, so no latch can be inferred.
    always_comb begin
        px_wrap = (px_q == HW'(H_TOTAL - 1));
        py_wrap = (py_q == VW'(V_TOTAL - 1));
        px_d    = px_wrap ? '0 : px_q + HW'(1);
        py_d    = py_q;
        if (px_wrap) begin
            py_d = py_wrap ? '0 : py_q + VW'(1);
        end
        frame_count_d = frame_count_q + 16'(px_wrap && py_wrap);

        raw.de = (px_q < HW'(H_ACTIVE)) && (py_q < VW'(V_ACTIVE));
        raw.hs = (px_q >= HW'(H_ACTIVE + H_FP)) && (px_q < HW'(H_ACTIVE + H_FP + H_SYNC));
        raw.vs = (py_q >= VW'(V_ACTIVE + V_FP)) && (py_q < VW'(V_ACTIVE + V_FP + V_SYNC));

        de_d    = dly.de;
        hsync_d = dly.hs ? HS_POL : !HS_POL;
        vsync_d = dly.vs ? VS_POL : !VS_POL;
        vga_d   = dly.de ? pix_in : '0;
    end

    vga_sync_delay #(
        .DEPTH (PIX_LAT)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (raw),
        .dout (dly)
    );

    // NOTE: state registers use non-blocking '<=' so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q          <= '0;
            py_q          <= '0;
            frame_count_q <= '0;
            de_q          <= 1'b0;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            vga_q         <= '0;
        end else begin
            px_q          <= px_d;
            py_q          <= py_d;
            frame_count_q <= frame_count_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vga_q         <= vga_d;
        end
    end

    // Strobes decode the counters directly, so they line up with px/py rather than the outputs.
    assign line_start  = (px_q == '0);
    assign frame_start = (px_q == '0) && (py_q == '0);

    assign px          = px_q;
    assign py          = py_q;
    assign frame_count = frame_count_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = vga_q.r;
    assign vga_g       = vga_q.g;
    assign vga_b       = vga_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: three vga_timing configurations against a cycle-count behavioural model.
module tb_vga_timing;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [15:0] px, py, fc;
        logic        ls, fs, hs, vs, de;
        logic [23:0] rgb;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   phase = 0;
    cfg_t cfg [3];
    logic [7:0] rin [3];
    logic [7:0] gin [3];
    logic [7:0] bcur [3];
    logic [7:0] bprev [3];

    logic [9:0] px0, py0; logic [2:0] px1, py1; logic [5:0] px2; logic [4:0] py2;
    logic [15:0] fc0, fc1, fc2;
    logic ls0, fs0, hs0, vs0, de0, ls1, fs1, hs1, vs1, de1, ls2, fs2, hs2, vs2, de2;
    logic [7:0] vr0, vg0, vb0, vr1, vg1, vb1, vr2, vg2, vb2;

    vga_timing u0 (
        .clk(clk), .rst(rst), .r(rin[0]), .g(gin[0]), .b(bcur[0]),
        .px(px0), .py(py0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0),
        .hsync(hs0), .vsync(vs0), .de(de0), .vga_r(vr0), .vga_g(vg0), .vga_b(vb0)
    );

    vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
    ) u1 (
        .clk(clk), .rst(rst), .r(rin[1]), .g(gin[1]), .b(bcur[1]),
        .px(px1), .py(py1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1),
        .hsync(hs1), .vsync(vs1), .de(de1), .vga_r(vr1), .vga_g(vg1), .vga_b(vb1)
    );

    vga_timing #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_LAT(3)
    ) u2 (
        .clk(clk), .rst(rst), .r(rin[2]), .g(gin[2]), .b(bcur[2]),
        .px(px2), .py(py2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2),
        .hsync(hs2), .vsync(vs2), .de(de2), .vga_r(vr2), .vga_g(vg2), .vga_b(vb2)
    );

    // Outputs in cycle m reflect the position of cycle m-lat-1; RGB is what was driven in m-1.
    function automatic obs_t model(cfg_t c, int m, logic [7:0] b_prev);
        obs_t e;
        int ht, vt, n, x, y;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        e.px = 16'(m % ht);
        e.py = 16'((m / ht) % vt);
        e.fc = 16'(m / (ht * vt));
        e.ls = (m % ht) == 0;
        e.fs = e.ls && ((m / ht) % vt) == 0;
        n = m - c.lat - 1;
        if (n < 0) begin
            e.de = 1'b0; e.hs = !c.hp; e.vs = !c.vp; e.rgb = '0;
        end else begin
            x = n % ht;
            y = (n / ht) % vt;
            e.de  = (x < c.ha) && (y < c.va);
            e.hs  = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.hp : !c.hp;
            e.vs  = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.vp : !c.vp;
            e.rgb = e.de ? {8'(x), 8'(y), b_prev} : 24'd0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Pixel source: echoes (x, y) of the coordinate issued lat clocks ago, random blue.
    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            int ht, vt, n;
            ht = cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
            vt = cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp;
            n  = cyc - cfg[i].lat;
            if (n >= 0) begin
                rin[i] = 8'(n % ht);
                gin[i] = 8'((n / ht) % vt);
            end else begin
                rin[i] = 8'($urandom);
                gin[i] = 8'($urandom);
            end
            bprev[i] = bcur[i];
            bcur[i]  = 8'($urandom);
        end
    endtask

    int fall0[$], rise0[$], fs1q[$], vfall2[$], vrise2[$];
    int first_hs1 = -1, first_de1 = -1, de2_cnt = 0, fs2_seen = 0, fc2_at_second = -1;
    logic prev_hs0 = 1'b1, prev_hs1 = 1'b0, prev_vs2 = 1'b1;

    task automatic compare();
        obs_t a [3];
        obs_t e;
        a[0] = '{16'(px0), 16'(py0), fc0, ls0, fs0, hs0, vs0, de0, {vr0, vg0, vb0}};
        a[1] = '{16'(px1), 16'(py1), fc1, ls1, fs1, hs1, vs1, de1, {vr1, vg1, vb1}};
        a[2] = '{16'(px2), 16'(py2), fc2, ls2, fs2, hs2, vs2, de2, {vr2, vg2, vb2}};
        for (int i = 0; i < 3; i++) begin
            e = rst ? model(cfg[i], 0, 8'd0) : model(cfg[i], cyc, bprev[i]);
            checks++;
            if (a[i] !== e) begin
                failures++;
                $display("FAIL cmp_u%0d cyc=%0d rst=%0b got px=%0d py=%0d fc=%0d ls=%0b fs=%0b hs=%0b vs=%0b de=%0b rgb=%h expected px=%0d py=%0d fc=%0d ls=%0b fs=%0b hs=%0b vs=%0b de=%0b rgb=%h",
                         i, cyc, rst, a[i].px, a[i].py, a[i].fc, a[i].ls, a[i].fs, a[i].hs, a[i].vs, a[i].de, a[i].rgb,
                         e.px, e.py, e.fc, e.ls, e.fs, e.hs, e.vs, e.de, e.rgb);
            end
        end
        if (!rst && phase == 1) begin
            if (prev_hs0 && !hs0) fall0.push_back(cyc);
            if (!prev_hs0 && hs0) rise0.push_back(cyc);
            prev_hs0 = hs0;
            if (!prev_hs1 && hs1 && first_hs1 < 0) first_hs1 = cyc;
            prev_hs1 = hs1;
            if (de1 && first_de1 < 0) first_de1 = cyc;
            if (fs1) fs1q.push_back(cyc);
            if (prev_vs2 && !vs2) vfall2.push_back(cyc);
            if (!prev_vs2 && vs2) vrise2.push_back(cyc);
            prev_vs2 = vs2;
            if (de2 && cyc < 1570) de2_cnt++;
            if (fs2) begin
                if (fs2_seen == 1) fc2_at_second = fc2;
                fs2_seen++;
            end
        end
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        cfg[1] = '{4, 1, 1, 1, 2, 1, 1, 1, 0, 1'b1, 1'b1};
        cfg[2] = '{40, 4, 8, 6, 20, 2, 2, 3, 3, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            rin[i] = '0; gin[i] = '0; bcur[i] = '0; bprev[i] = '0;
        end

        repeat (5) begin
            @(negedge clk);
            compare();
        end
        check("rst_hsync", int'(hs0), 1);
        check("rst_vsync", int'(vs0), 1);
        check("rst_de", int'(de0), 0);
        check("rst_rgb", int'({vr0, vg0, vb0}), 0);
        check("rst_line_start", int'(ls0), 1);
        check("rst_frame_start", int'(fs0), 1);

        @(posedge clk); #1;
        rst = 1'b0; cyc = 0; phase = 1;
        drive();
        check("first_px", int'(px0), 0);
        check("first_py", int'(py0), 0);

        // Two full u2 frames, then on to (30,15) of its third frame.
        while (cyc < 4032) begin
            @(negedge clk);
            compare();
            @(posedge clk); #1;
            cyc++;
            drive();
        end
        @(negedge clk);
        compare();
        check("pre_rst_px2", int'(px2), 30);
        check("pre_rst_py2", int'(py2), 15);
        check("pre_rst_fc2", int'(fc2), 2);
        check("pre_rst_de2", int'(de2), 1);
        #1 rst = 1'b1;
        #1;
        phase = 2;
        check("async_rst_px2", int'(px2), 0);
        check("async_rst_py2", int'(py2), 0);
        check("async_rst_fc2", int'(fc2), 0);
        check("async_rst_de2", int'(de2), 0);
        check("async_rst_hs2", int'(hs2), 1);
        check("async_rst_rgb2", int'({vr2, vg2, vb2}), 0);
        repeat (3) begin
            @(negedge clk);
            compare();
        end

        @(posedge clk); #1;
        rst = 1'b0; cyc = 0;
        drive();
        check("restart_px2", int'(px2), 0);
        check("restart_py2", int'(py2), 0);
        check("restart_fc2", int'(fc2), 0);
        while (cyc < 200) begin
            @(negedge clk);
            compare();
            @(posedge clk); #1;
            cyc++;
            drive();
        end

        check("hs_fall_pos", (fall0.size() > 0) ? fall0[0] : -1, 659);
        check("hs_low_width", (fall0.size() > 0 && rise0.size() > 0) ? rise0[0] - fall0[0] : -1, 96);
        check("hs_period", (fall0.size() > 1) ? fall0[1] - fall0[0] : -1, 800);
        check("u1_first_hs_high", first_hs1, 6);
        check("u1_first_de", first_de1, 1);
        check("u1_frame_period", (fs1q.size() > 1) ? fs1q[1] - fs1q[0] : -1, 35);
        check("u2_vs_fall", (vfall2.size() > 0) ? vfall2[0] : -1, 1280);
        check("u2_vs_width", (vfall2.size() > 0 && vrise2.size() > 0) ? vrise2[0] - vfall2[0] : -1, 116);
        check("u2_fc_at_second_fs", fc2_at_second, 1);
        check("u2_de_per_frame", de2_cnt, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
